control_buscaminas: RTL and testbench

CONTROL_BUSCAMINAS -- requirements
Module: control_buscaminas

---
 rtl/control_buscaminas.sv | 213 +++++++++++++++++++++
 tb/tb_control_buscaminas.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_buscaminas.sv
// rtl/control_buscaminas.sv - minesweeper game controller: bomb placement, count wait, reveal handling
module control_buscaminas (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic [5:0]            num_bombs,
  input  logic [15:0]           seed,
  input  logic                  reveal_valid,
  input  logic [2:0]            reveal_row,
  input  logic [2:0]            reveal_col,
  output logic                  reveal_ready,
  output logic [7:0][7:0][3:0]  matrizBombastic,
  input  logic [7:0][7:0][3:0]  matrizNumeros,
  output logic                  resp_valid,
  output logic [3:0]            resp_value,
  output logic [63:0]           revealed,
  output logic [2:0]            state,
  output logic                  win,
  output logic                  lose
);

  localparam logic [2:0]  ST_IDLE  = 3'd0;
  localparam logic [2:0]  ST_PLACE = 3'd1;
  localparam logic [2:0]  ST_COUNT = 3'd2;
  localparam logic [2:0]  ST_PLAY  = 3'd3;
  localparam logic [2:0]  ST_WIN   = 3'd4;
  localparam logic [2:0]  ST_LOSE  = 3'd5;

  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;
  localparam logic [3:0]  CELL_BOMB    = 4'hF;
  localparam logic [3:0]  CELL_EMPTY   = 4'h0;

  logic [2:0]  state_next;
  logic [15:0] lfsr;
  logic        lfsr_feedback;
  logic [5:0]  bomb_target;
  logic [5:0]  placed_count;
  logic        count_phase;
  logic [6:0]  safe_count;
  logic [6:0]  safe_target;

  logic        start_accept;
  logic        reveal_accept;
  logic [5:0]  reveal_index;
  logic        reveal_is_bomb;
  logic        reveal_is_new;
  logic        reveal_wins;
  logic        place_done;
  logic        place_hit;
  logic        place_active;
  logic        game_over_next;

  // Decode of the handshake and placement conditions shared by the FSM and datapath
  always_comb begin
    start_accept   = start && ((state == ST_IDLE) || (state == ST_WIN) || (state == ST_LOSE));
    reveal_accept  = reveal_valid && reveal_ready;
    reveal_index   = {reveal_row, reveal_col};
    reveal_is_bomb = (matrizBombastic[reveal_row][reveal_col] == CELL_BOMB);
    reveal_is_new  = !revealed[reveal_index];
    safe_target    = 7'd64 - {1'b0, bomb_target};
    reveal_wins    = reveal_accept && !reveal_is_bomb && reveal_is_new &&
                     ((safe_count + 7'd1) == safe_target);
    place_done     = (placed_count == bomb_target);
    place_active   = (state == ST_PLACE) && !place_done;
    place_hit      = (matrizBombastic[lfsr[5:3]][lfsr[2:0]] == CELL_EMPTY);
    lfsr_feedback  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    game_over_next = (state == ST_PLAY) && ((state_next == ST_WIN) || (state_next == ST_LOSE));
  end

  // State register
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start only matters between games, a bomb reveal beats a win
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start_accept) state_next = ST_PLACE;
      end
      ST_PLACE: begin
        if (place_done) state_next = ST_COUNT;
      end
      ST_COUNT: begin
        if (count_phase) state_next = ST_PLAY;
      end
      ST_PLAY: begin
        if (reveal_accept) begin
          if (reveal_is_bomb) begin
            state_next = ST_LOSE;
          end else if (reveal_wins) begin
            state_next = ST_WIN;
          end
        end
      end
      ST_WIN, ST_LOSE: begin
        if (start_accept) state_next = ST_PLACE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    reveal_ready = 1'b0;
    win          = 1'b0;
    lose         = 1'b0;
    case (state)
      ST_PLAY: reveal_ready = 1'b1;
      ST_WIN:  win          = 1'b1;
      ST_LOSE: lose         = 1'b1;
      default: begin
        reveal_ready = 1'b0;
      end
    endcase
  end

  // LFSR: seeded on start (zero seed would lock up), steps every PLACE cycle
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      lfsr <= LFSR_DEFAULT;
    end else if (start_accept) begin
      lfsr <= (seed == 16'd0) ? LFSR_DEFAULT : seed;
    end else if (state == ST_PLACE) begin
      lfsr <= {lfsr[14:0], lfsr_feedback};
    end
  end

  // Requested bomb count, at least one so the game can always be lost
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      bomb_target <= 6'd0;
    end else if (start_accept) begin
      bomb_target <= (num_bombs == 6'd0) ? 6'd1 : num_bombs;
    end
  end

  // Number of bombs placed so far; repeats of an occupied cell are skipped
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      placed_count <= 6'd0;
    end else if (start_accept) begin
      placed_count <= 6'd0;
    end else if (place_active && place_hit) begin
      placed_count <= placed_count + 6'd1;
    end
  end

  // Two-cycle COUNT window so the counting datapath sees a stable board
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      count_phase <= 1'b0;
    end else if (state == ST_COUNT) begin
      count_phase <= ~count_phase;
    end else begin
      count_phase <= 1'b0;
    end
  end

  // Board: cleared on start, written only during PLACE, frozen afterwards
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      matrizBombastic <= '0;
    end else if (start_accept) begin
      matrizBombastic <= '0;
    end else if (place_active && place_hit) begin
      matrizBombastic[lfsr[5:3]][lfsr[2:0]] <= CELL_BOMB;
    end
  end

  // Revealed mask: one bit per accepted reveal, whole board opened when the game ends
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      revealed <= 64'd0;
    end else if (start_accept) begin
      revealed <= 64'd0;
    end else if (game_over_next) begin
      revealed <= {64{1'b1}};
    end else if (reveal_accept) begin
      revealed[reveal_index] <= 1'b1;
    end
  end

  // Safe-cell counter: only first-time reveals of non-bomb cells advance it
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      safe_count <= 7'd0;
    end else if (start_accept) begin
      safe_count <= 7'd0;
    end else if (reveal_accept && !reveal_is_bomb && reveal_is_new) begin
      safe_count <= safe_count + 7'd1;
    end
  end

  // Response: one-cycle pulse after each accepted reveal, bombs always report 15
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_value <= 4'd0;
    end else begin
      resp_valid <= reveal_accept;
      if (reveal_accept) begin
        resp_value <= reveal_is_bomb ? CELL_BOMB : matrizNumeros[reveal_row][reveal_col];
      end
    end
  end

endmodule

// File: tb/tb_control_buscaminas.sv
// tb/tb_control_buscaminas.sv - scoreboard bench for control_buscaminas
module tb_control_buscaminas;

  logic                 clock = 1'b0;
  logic                 rst;
  logic                 start;
  logic [5:0]           num_bombs;
  logic [15:0]          seed;
  logic                 reveal_valid;
  logic [2:0]           reveal_row;
  logic [2:0]           reveal_col;
  logic                 reveal_ready;
  logic [7:0][7:0][3:0] matrizBombastic;
  logic [7:0][7:0][3:0] matrizNumeros;
  logic                 resp_valid;
  logic [3:0]           resp_value;
  logic [63:0]          revealed;
  logic [2:0]           state;
  logic                 win;
  logic                 lose;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  exp_q[$];
  logic [63:0] model_mask;
  int          model_steps;
  int          s0, s1, s2, b0;

  always #5 clock = ~clock;

  control_buscaminas dut (
    .clock           (clock),
    .rst             (rst),
    .start           (start),
    .num_bombs       (num_bombs),
    .seed            (seed),
    .reveal_valid    (reveal_valid),
    .reveal_row      (reveal_row),
    .reveal_col      (reveal_col),
    .reveal_ready    (reveal_ready),
    .matrizBombastic (matrizBombastic),
    .matrizNumeros   (matrizNumeros),
    .resp_valid      (resp_valid),
    .resp_value      (resp_value),
    .revealed        (revealed),
    .state           (state),
    .win             (win),
    .lose            (lose)
  );

  function automatic logic [3:0] pat(input int idx);
    int t;
    t = ((idx >> 3) * 3 + (idx & 7)) % 9;
    return t[3:0];
  endfunction

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] dut_mask();
    logic [63:0] m;
    for (int i = 0; i < 64; i++) m[i] = (matrizBombastic[i >> 3][i & 7] == 4'hF);
    return m;
  endfunction

  function automatic logic [63:0] dut_zero_cells();
    logic [63:0] m;
    for (int i = 0; i < 64; i++) m[i] = (matrizBombastic[i >> 3][i & 7] == 4'h0);
    return m;
  endfunction

  function automatic int popcount(input logic [63:0] m);
    int n = 0;
    for (int i = 0; i < 64; i++) n += m[i] ? 1 : 0;
    return n;
  endfunction

  task automatic model_place(input logic [5:0] n, input logic [15:0] s);
    logic [15:0] l;
    int placed;
    int target;
    target = (n == 6'd0) ? 1 : int'(n);
    l = (s == 16'd0) ? 16'hACE1 : s;
    model_mask = 64'd0;
    placed = 0;
    model_steps = 0;
    while (placed < target && model_steps < 70000) begin
      if (!model_mask[l[5:0]]) begin
        model_mask[l[5:0]] = 1'b1;
        placed++;
      end
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      model_steps++;
    end
  endtask

  task automatic start_game(input logic [5:0] n, input logic [15:0] s);
    start = 1'b1;
    num_bombs = n;
    seed = s;
    tick();
    start = 1'b0;
    check("start_enters_place", state, 3'd1);
  endtask

  task automatic wait_state(input logic [2:0] code, input int budget, input string name);
    int n = 0;
    while (state !== code && n < budget) begin
      tick();
      n++;
    end
    check(name, state, code);
  endtask

  task automatic reveal(input int idx);
    check("reveal_ready_in_play", reveal_ready, 1'b1);
    reveal_valid = 1'b1;
    reveal_row = idx[5:3];
    reveal_col = idx[2:0];
    exp_q.push_back(model_mask[idx] ? 4'hF : pat(idx));
    tick();
    reveal_valid = 1'b0;
  endtask

  task automatic check_idle_clear(input string tag);
    check({tag, "_state"}, state, 3'd0);
    check({tag, "_revealed"}, revealed, 64'd0);
    check({tag, "_board"}, dut_zero_cells(), {64{1'b1}});
    check({tag, "_ready"}, reveal_ready, 1'b0);
    check({tag, "_winlose"}, {win, lose}, 2'b00);
  endtask

  // Scoreboard monitor: every response pulse must match the oldest expectation
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clock);
      if (resp_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: got value %0d with no reveal outstanding", resp_value);
        end else begin
          e = exp_q.pop_front();
          if (resp_value !== e) begin
            errors++;
            $display("FAIL resp_value: got %0d expected %0d", resp_value, e);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    num_bombs = 6'd0;
    seed = 16'd0;
    reveal_valid = 1'b0;
    reveal_row = 3'd0;
    reveal_col = 3'd0;
    for (int i = 0; i < 64; i++) matrizNumeros[i >> 3][i & 7] = pat(i);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_idle_clear("reset");
    check("reset_resp_valid", resp_valid, 1'b0);
    check("reset_lfsr", dut.lfsr, 16'hACE1);
    check("reset_safe_count", dut.safe_count, 7'd0);

    // Ten bombs from seed 1234
    model_place(6'd10, 16'h1234);
    start_game(6'd10, 16'h1234);
    wait_state(3'd2, model_steps + 10, "reach_count_10");
    check("bombs_10_count", popcount(dut_mask()), 10);
    check("bombs_10_layout", dut_mask(), model_mask);
    tick();
    check("count_cycle2_state", state, 3'd2);
    check("count_board_stable", dut_mask(), model_mask);
    tick();
    check("count_to_play", state, 3'd3);

    s0 = -1; s1 = -1; s2 = -1; b0 = -1;
    for (int i = 0; i < 64; i++) begin
      if (model_mask[i]) begin
        if (b0 < 0) b0 = i;
      end else if (s0 < 0) s0 = i;
      else if (s1 < 0) s1 = i;
      else if (s2 < 0) s2 = i;
    end

    reveal(s0);
    check("reveal_bit_set", revealed[s0], 1'b1);
    check("safe_count_1", dut.safe_count, 7'd1);
    start = 1'b1;
    num_bombs = 6'd3;
    reveal(s0);
    start = 1'b0;
    check("start_ignored_in_play", state, 3'd3);
    check("rereveal_no_count", dut.safe_count, 7'd1);
    reveal(s1);
    reveal(s2);
    check("back_to_back_count", dut.safe_count, 7'd3);
    check("revealed_mask_3", revealed, (64'd1 << s0) | (64'd1 << s1) | (64'd1 << s2));

    reveal(b0);
    check("lose_state", state, 3'd5);
    check("lose_flags", {win, lose}, 2'b01);
    check("lose_revealed_all", revealed, {64{1'b1}});
    check("lose_ready", reveal_ready, 1'b0);
    tick();
    tick();
    check("lose_board_held", dut_mask(), model_mask);

    // Zero bombs and zero seed, restarted from LOSE
    model_place(6'd0, 16'd0);
    start_game(6'd0, 16'd0);
    check("zero_seed_lfsr", dut.lfsr, 16'hACE1);
    check("restart_revealed_clear", revealed, 64'd0);
    check("restart_board_clear", dut_zero_cells(), {64{1'b1}});
    wait_state(3'd2, model_steps + 10, "reach_count_1");
    check("bombs_1_count", popcount(dut_mask()), 1);
    check("bombs_1_layout", dut_mask(), model_mask);
    wait_state(3'd3, 4, "reach_play_1");

    // Asynchronous reset in the middle of a game
    s0 = model_mask[0] ? 1 : 0;
    reveal(s0);
    tick();
    rst = 1'b1;
    #1;
    check("async_reset_state", state, 3'd0);
    tick();
    rst = 1'b0;
    tick();
    check_idle_clear("midgame_reset");
    check("midgame_reset_safe", dut.safe_count, 7'd0);
    tick();
    tick();
    check("stays_idle", state, 3'd0);

    // 63 bombs: one safe cell wins the game
    model_place(6'd63, 16'hBEEF);
    start_game(6'd63, 16'hBEEF);
    wait_state(3'd2, model_steps + 10, "reach_count_63");
    check("bombs_63_count", popcount(dut_mask()), 63);
    check("bombs_63_layout", dut_mask(), model_mask);
    wait_state(3'd3, 4, "reach_play_63");
    s0 = 0;
    for (int i = 0; i < 64; i++) if (!model_mask[i]) s0 = i;
    reveal(s0);
    check("win_state", state, 3'd4);
    check("win_flags", {win, lose}, 2'b10);
    check("win_revealed_all", revealed, {64{1'b1}});
    check("win_ready", reveal_ready, 1'b0);
    start_game(6'd5, 16'h0001);
    check("after_win_board_clear", dut_zero_cells(), {64{1'b1}});
    check("after_win_revealed_clear", revealed, 64'd0);
    check("after_win_flags", {win, lose}, 2'b00);

    tick();
    tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
